// File: rtl/mux153_rr_arbiter_pkg.sv
// rtl/mux153_rr_arbiter_pkg.sv - shared types and constants for the selector arbiter
package mux_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/mux153_rr_arbiter_if.sv
// rtl/mux153_rr_arbiter_if.sv - request/grant and selector control bundle
interface mux153_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               S1;
  logic               S0;
  logic               E1_N;
  logic               E2_N;
  logic               busy;
  logic               preempt;

  // requester side drives req and watches the grant/selector controls
  modport master (
    output req,
    input  gnt, S1, S0, E1_N, E2_N, busy, preempt
  );

  // arbiter side
  modport slave (
    input  req,
    output gnt, S1, S0, E1_N, E2_N, busy, preempt
  );
endinterface

// File: rtl/mux153_rr_arbiter_rr_pick4.sv
// rtl/mux153_rr_arbiter_rr_pick4.sv - round-robin winner search starting after last
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic               valid,
  output logic [1:0]         idx
);

  logic [1:0] cand;

  // walk offsets 4..1 so the closest requester after last overwrites the others;
  // offset 4 wraps to last itself, so it only wins when nobody else is asking
  always_comb begin
    valid = 1'b0;
    idx   = 2'd0;
    cand  = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux153_rr_arbiter.sv
// rtl/mux153_rr_arbiter.sv - round-robin owner of a shared dual 4-to-1 selector
module mux153_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
)
(
  input  logic                clock_50,
  input  logic                reset,
  mux153_rr_arbiter_if.slave  bus
);

  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t          state_q, state_n;
  logic [1:0]      last_q, last_n;
  logic [HW-1:0]   cnt_q, cnt_n;
  logic            pre_flag_q, pre_flag_n;

  logic            pick_valid;
  logic [1:0]      pick_idx;

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]         sel_q, sel_d;
  logic               en_n_q, en_n_d;
  logic               busy_q, busy_d;
  logic               pre_q, pre_d;

  rr_pick4 u_pick (
    .req   (bus.req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // state register: FSM state, last winner, hold counter, preempt cause
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 2'd3;
      cnt_q      <= '0;
      pre_flag_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      last_q     <= last_n;
      cnt_q      <= cnt_n;
      pre_flag_q <= pre_flag_n;
    end
  end

  // next-state: release wins over hold limit when both happen on one edge
  always_comb begin
    state_n    = state_q;
    last_n     = last_q;
    cnt_n      = cnt_q;
    pre_flag_n = pre_flag_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_n = GRANT;
          last_n  = pick_idx;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (!bus.req[last_q]) begin
          state_n    = GAP;
          pre_flag_n = 1'b0;
        end else if ((MAX_HOLD != 0) && (cnt_q == HOLD_LIM)) begin
          state_n    = GAP;
          pre_flag_n = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_n = cnt_q + HW'(1);
        end
      end
      GAP: begin
        if (pick_valid) begin
          state_n = GRANT;
          last_n  = pick_idx;
          cnt_n   = '0;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // output decode: select pins only move while the enables are high
  always_comb begin
    gnt_d  = '0;
    sel_d  = sel_q;
    en_n_d = 1'b1;
    busy_d = (state_q != IDLE);
    pre_d  = (state_q == GAP) && pre_flag_q;
    if (state_q == GRANT) begin
      gnt_d  = NUM_REQ'(1) << last_q;
      sel_d  = last_q;
      en_n_d = 1'b0;
    end
  end

  // output registers keep req off any combinational path to the pins
  always_ff @(posedge clock_50) begin
    if (reset) begin
      gnt_q  <= '0;
      sel_q  <= 2'd0;
      en_n_q <= 1'b1;
      busy_q <= 1'b0;
      pre_q  <= 1'b0;
    end else begin
      gnt_q  <= gnt_d;
      sel_q  <= sel_d;
      en_n_q <= en_n_d;
      busy_q <= busy_d;
      pre_q  <= pre_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.S1      = sel_q[1];
  assign bus.S0      = sel_q[0];
  assign bus.E1_N    = en_n_q;
  assign bus.E2_N    = en_n_q;
  assign bus.busy    = busy_q;
  assign bus.preempt = pre_q;

endmodule

// File: tb/tb_mux153_rr_arbiter.sv
// tb/tb_mux153_rr_arbiter.sv - scoreboard bench for the selector arbiter
module tb_mux153_rr_arbiter;

  logic clock_50 = 1'b0;
  logic reset;

  always #10 clock_50 = ~clock_50;

  mux153_rr_arbiter_if if4 ();
  mux153_rr_arbiter_if if3 ();

  mux153_rr_arbiter #(.MAX_HOLD(4)) u_dut4 (.clock_50(clock_50), .reset(reset), .bus(if4.slave));
  mux153_rr_arbiter #(.MAX_HOLD(3)) u_dut3 (.clock_50(clock_50), .reset(reset), .bus(if3.slave));

  typedef struct {
    logic [9:0] v;
    logic [9:0] m;
    logic [7:0] y1;
    logic [7:0] y2;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [9:0] M_ALL   = 10'b1111_11_11_1_1;
  localparam logic [9:0] M_NOSEL = 10'b1111_00_11_1_1;

  // selector input lines: requester r presents I1=A0+r, I2=50+r
  function automatic logic [7:0] sel_in(input logic half2, input logic [1:0] s);
    return half2 ? (8'h50 + {6'b0, s}) : (8'hA0 + {6'b0, s});
  endfunction

  // observed {gnt, S1, S0, E1_N, E2_N, busy, preempt} and selector outputs
  logic [9:0] o4, o3;
  logic [7:0] y1_4, y2_4, y1_3, y2_3;
  assign o4   = {if4.gnt, if4.S1, if4.S0, if4.E1_N, if4.E2_N, if4.busy, if4.preempt};
  assign o3   = {if3.gnt, if3.S1, if3.S0, if3.E1_N, if3.E2_N, if3.busy, if3.preempt};
  assign y1_4 = if4.E1_N ? 8'h00 : sel_in(1'b0, {if4.S1, if4.S0});
  assign y2_4 = if4.E2_N ? 8'h00 : sel_in(1'b1, {if4.S1, if4.S0});
  assign y1_3 = if3.E1_N ? 8'h00 : sel_in(1'b0, {if3.S1, if3.S0});
  assign y2_3 = if3.E2_N ? 8'h00 : sel_in(1'b1, {if3.S1, if3.S0});

  task automatic push_idle(input logic [9:0] m);
    exp_q.push_back('{v: 10'b0000_00_11_0_0, m: m, y1: 8'h00, y2: 8'h00});
  endtask

  task automatic push_grant(input int i, input int n);
    logic [1:0] s;
    s = 2'(i);
    repeat (n)
      exp_q.push_back('{v: {4'(1 << i), s, 2'b00, 1'b1, 1'b0}, m: M_ALL,
                        y1: sel_in(1'b0, s), y2: sel_in(1'b1, s)});
  endtask

  task automatic push_gap(input int s, input logic p);
    exp_q.push_back('{v: {4'b0000, 2'(s), 2'b11, 1'b1, p}, m: M_ALL, y1: 8'h00, y2: 8'h00});
  endtask

  task automatic test_reset();
    exp_t e;
    reset   = 1'b1;
    if4.req = 4'b1111;
    if3.req = 4'b0000;
    repeat (2) @(posedge clock_50);
    push_idle(M_ALL);
    push_idle(M_ALL);
    push_grant(0, 1);
    push_grant(0, 1);
    push_gap(0, 1'b0);
    push_idle(M_NOSEL);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock_50);
      e = exp_q.pop_front();
      checks++;
      if (((o4 & e.m) !== (e.v & e.m)) || (y1_4 !== e.y1) || (y2_4 !== e.y2)) begin
        errors++;
        $display("FAIL reset[%0d]: out=%b y=%h/%h required %b y=%h/%h mask %b",
                 c, o4, y1_4, y2_4, e.v, e.y1, e.y2, e.m);
      end
      if (c == 0) reset = 1'b0;
      if (c == 2) if4.req = 4'b0000;
    end
  endtask

  task automatic test_single();
    exp_t e;
    if4.req = 4'b0010;
    push_idle(M_NOSEL);
    push_grant(1, 4);
    push_gap(1, 1'b0);
    push_idle(M_NOSEL);
    for (int c = 0; c < 7; c++) begin
      @(negedge clock_50);
      e = exp_q.pop_front();
      checks++;
      if (((o4 & e.m) !== (e.v & e.m)) || (y1_4 !== e.y1) || (y2_4 !== e.y2)) begin
        errors++;
        $display("FAIL single[%0d]: out=%b y=%h/%h required %b y=%h/%h mask %b",
                 c, o4, y1_4, y2_4, e.v, e.y1, e.y2, e.m);
      end
      if (c == 3) if4.req = 4'b0000;
    end
  endtask

  task automatic test_rotation();
    exp_t e;
    if4.req = 4'b0101;
    push_idle(M_NOSEL);
    for (int t = 0; t < 4; t++) begin
      push_grant((t % 2 == 0) ? 2 : 0, 4);
      push_gap((t % 2 == 0) ? 2 : 0, 1'b1);
    end
    while (exp_q.size() != 0) begin
      @(negedge clock_50);
      e = exp_q.pop_front();
      checks++;
      if (((o4 & e.m) !== (e.v & e.m)) || (y1_4 !== e.y1) || (y2_4 !== e.y2)) begin
        errors++;
        $display("FAIL rotation: out=%b y=%h/%h required %b y=%h/%h mask %b",
                 o4, y1_4, y2_4, e.v, e.y1, e.y2, e.m);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    push_grant(2, 1);
    push_idle(M_ALL);
    push_idle(M_ALL);
    push_grant(0, 2);
    push_gap(0, 1'b0);
    push_idle(M_NOSEL);
    for (int c = 0; c < 7; c++) begin
      @(negedge clock_50);
      e = exp_q.pop_front();
      checks++;
      if (((o4 & e.m) !== (e.v & e.m)) || (y1_4 !== e.y1) || (y2_4 !== e.y2)) begin
        errors++;
        $display("FAIL reset_mid[%0d]: out=%b y=%h/%h required %b y=%h/%h mask %b",
                 c, o4, y1_4, y2_4, e.v, e.y1, e.y2, e.m);
      end
      if (c == 0) reset = 1'b1;
      if (c == 1) reset = 1'b0;
      if (c == 3) if4.req = 4'b0000;
    end
  endtask

  task automatic test_datapath();
    exp_t e;
    int order[4] = '{1, 2, 3, 0};
    if4.req = 4'b1111;
    push_idle(M_NOSEL);
    foreach (order[k]) begin
      push_grant(order[k], 4);
      push_gap(order[k], 1'b1);
    end
    push_grant(1, 1);
    push_gap(1, 1'b0);
    push_idle(M_NOSEL);
    for (int c = 0; c < 24; c++) begin
      @(negedge clock_50);
      e = exp_q.pop_front();
      checks++;
      if (((o4 & e.m) !== (e.v & e.m)) || (y1_4 !== e.y1) || (y2_4 !== e.y2)) begin
        errors++;
        $display("FAIL datapath[%0d]: out=%b y=%h/%h required %b y=%h/%h mask %b",
                 c, o4, y1_4, y2_4, e.v, e.y1, e.y2, e.m);
      end
      if (c == 20) if4.req = 4'b0000;
    end
  endtask

  task automatic test_sole_hog();
    exp_t e;
    if3.req = 4'b1000;
    push_idle(M_NOSEL);
    repeat (3) begin
      push_grant(3, 3);
      push_gap(3, 1'b1);
    end
    push_grant(3, 1);
    push_gap(3, 1'b0);
    push_idle(M_NOSEL);
    for (int c = 0; c < 16; c++) begin
      @(negedge clock_50);
      e = exp_q.pop_front();
      checks++;
      if (((o3 & e.m) !== (e.v & e.m)) || (y1_3 !== e.y1) || (y2_3 !== e.y2)) begin
        errors++;
        $display("FAIL sole_hog[%0d]: out=%b y=%h/%h required %b y=%h/%h mask %b",
                 c, o3, y1_3, y2_3, e.v, e.y1, e.y2, e.m);
      end
      if (c == 12) if3.req = 4'b0000;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_reset_mid();
    test_datapath();
    test_sole_hog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
